antares_memory_arbiter: RTL and testbench

- Shares one external memory bus between the instruction port (iport) and data port (dport) of the load/store unit.
- Each side uses the 4-way enable/ready handshake:
  1. Enable rises.
  2. Ready rises.
  3. Enable falls.
  4. Ready clears the next cycle.
- Serialises requests with data-first priority plus alternation under contention.
- Adds a no-response timeout that converts to a bus error.

---
 rtl/antares_memory_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_antares_memory_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/antares_memory_arbiter.sv
// antares_memory_arbiter
// Shares one external memory bus between the LSU instruction port (iport)
// and data port (dport). Each side uses a 4-way enable/ready handshake.
// Data wins when only it requests or when the instruction port won last.
// Back-to-back contention therefore alternates D, I, D, I.
// A BUSY phase that sees no mem_ready/mem_error for TIMEOUT_CYCLES cycles
// completes with a bus error. If TIMEOUT_CYCLES is 0, the timeout is disabled.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   iport_address/wr/enable  instruction request from LSU
//   iport_data_i/ready/error instruction response to LSU (registered)
//   dport_address/data_o/wr/enable  data request from LSU
//   dport_data_i/ready/error data response to LSU (registered)
//   mem_address/data_o/wr    shared bus request, muxed from registered grant
//   mem_enable               shared bus request strobe (registered)
//   mem_data_i/ready/error   shared bus response
//   grant_d                  1 while the data port owns the bus
//   arb_busy                 1 whenever the arbiter is not idle
module antares_memory_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iport_address,
   input  logic [3:0]  iport_wr,
   input  logic        iport_enable,
   output logic [31:0] iport_data_i,
   output logic        iport_ready,
   output logic        iport_error,
   input  logic [31:0] dport_address,
   input  logic [31:0] dport_data_o,
   input  logic [3:0]  dport_wr,
   input  logic        dport_enable,
   output logic [31:0] dport_data_i,
   output logic        dport_ready,
   output logic        dport_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_o,
   output logic [3:0]  mem_wr,
   output logic        mem_enable,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ready,
   input  logic        mem_error,
   output logic        grant_d,
   output logic        arb_busy
);

   localparam int unsigned CNT_W    = 16;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      DONE_I = 3'd3,
      DONE_D = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic             last_d, last_d_nxt;
   logic             abort, abort_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic [31:0] iport_data_nxt, dport_data_nxt;
   logic        iport_ready_nxt, iport_error_nxt;
   logic        dport_ready_nxt, dport_error_nxt;
   logic        mem_enable_nxt, grant_d_nxt, arb_busy_nxt;

   logic        busy_d_c, x_enable_c, aborting_c, timeout_c, finish_c;

   // The counter holds the number of BUSY cycles already completed.
   // The current cycle is therefore cycle cnt+1. The timeout fires at the
   // end of the TIMEOUT_CYCLES-th BUSY cycle, so mem_enable stays high for
   // exactly TIMEOUT_CYCLES cycles.
   always_comb begin
      busy_d_c   = (state == BUSY_D);
      x_enable_c = busy_d_c ? dport_enable : iport_enable;
      aborting_c = abort | ~x_enable_c;
      timeout_c  = TO_EN && (cnt == TO_LIMIT - CNT_W'(1));
      finish_c   = mem_ready | mem_error | timeout_c;
   end

   // State register and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_d       <= 1'b0;
         abort        <= 1'b0;
         cnt          <= '0;
         iport_data_i <= '0;
         iport_ready  <= 1'b0;
         iport_error  <= 1'b0;
         dport_data_i <= '0;
         dport_ready  <= 1'b0;
         dport_error  <= 1'b0;
         mem_enable   <= 1'b0;
         grant_d      <= 1'b0;
         arb_busy     <= 1'b0;
      end else begin
         state        <= state_nxt;
         last_d       <= last_d_nxt;
         abort        <= abort_nxt;
         cnt          <= cnt_nxt;
         iport_data_i <= iport_data_nxt;
         iport_ready  <= iport_ready_nxt;
         iport_error  <= iport_error_nxt;
         dport_data_i <= dport_data_nxt;
         dport_ready  <= dport_ready_nxt;
         dport_error  <= dport_error_nxt;
         mem_enable   <= mem_enable_nxt;
         grant_d      <= grant_d_nxt;
         arb_busy     <= arb_busy_nxt;
      end
   end

   // Next-state, arbitration and response logic
   always_comb begin
      state_nxt       = state;
      last_d_nxt      = last_d;
      abort_nxt       = abort;
      cnt_nxt         = cnt;
      iport_data_nxt  = iport_data_i;
      iport_ready_nxt = iport_ready;
      iport_error_nxt = iport_error;
      dport_data_nxt  = dport_data_i;
      dport_ready_nxt = dport_ready;
      dport_error_nxt = dport_error;

      case (state)
         IDLE: begin
            cnt_nxt   = '0;
            abort_nxt = 1'b0;
            if (dport_enable && (!iport_enable || !last_d)) begin
               state_nxt = BUSY_D;
            end else if (iport_enable) begin
               state_nxt = BUSY_I;
            end
         end

         BUSY_I, BUSY_D: begin
            cnt_nxt   = (cnt == TO_LIMIT) ? cnt : cnt + CNT_W'(1);
            abort_nxt = aborting_c;
            if (finish_c) begin
               last_d_nxt = busy_d_c;
               abort_nxt  = 1'b0;
               if (aborting_c) begin
                  // Flushed request: the bus finishes, but the LSU sees no response.
                  state_nxt = IDLE;
               end else if (busy_d_c) begin
                  state_nxt       = DONE_D;
                  dport_ready_nxt = mem_ready;
                  dport_error_nxt = mem_error | (timeout_c & ~mem_ready);
                  if (mem_ready) dport_data_nxt = mem_data_i;
               end else begin
                  state_nxt       = DONE_I;
                  iport_ready_nxt = mem_ready;
                  iport_error_nxt = mem_error | (timeout_c & ~mem_ready);
                  if (mem_ready) iport_data_nxt = mem_data_i;
               end
            end
         end

         DONE_I: begin
            if (!iport_enable) begin
               iport_ready_nxt = 1'b0;
               iport_error_nxt = 1'b0;
               state_nxt       = IDLE;
            end
         end

         DONE_D: begin
            if (!dport_enable) begin
               dport_ready_nxt = 1'b0;
               dport_error_nxt = 1'b0;
               state_nxt       = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase

      mem_enable_nxt = (state_nxt == BUSY_I) || (state_nxt == BUSY_D);
      grant_d_nxt    = (state_nxt == BUSY_D) || (state_nxt == DONE_D);
      arb_busy_nxt   = (state_nxt != IDLE);
   end

   // Shared bus request: driven only during BUSY, otherwise all zero.
   // Because the registered mem_enable and grant_d reset asynchronously,
   // these outputs drop immediately on reset.
   always_comb begin
      mem_address = '0;
      mem_data_o  = '0;
      mem_wr      = '0;
      if (mem_enable) begin
         if (grant_d) begin
            mem_address = dport_address;
            mem_data_o  = dport_data_o;
            mem_wr      = dport_wr;
         end else begin
            mem_address = iport_address;
            mem_wr      = iport_wr;
         end
      end
   end

endmodule

// File: tb/tb_antares_memory_arbiter.sv
module tb_antares_memory_arbiter;

   localparam int unsigned T = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] iport_address;
   logic [3:0]  iport_wr;
   logic        iport_enable;
   logic [31:0] iport_data_i;
   logic        iport_ready, iport_error;
   logic [31:0] dport_address, dport_data_o;
   logic [3:0]  dport_wr;
   logic        dport_enable;
   logic [31:0] dport_data_i;
   logic        dport_ready, dport_error;
   logic [31:0] mem_address, mem_data_o;
   logic [3:0]  mem_wr;
   logic        mem_enable;
   logic [31:0] mem_data_i;
   logic        mem_ready, mem_error;
   logic        grant_d, arb_busy;

   antares_memory_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .iport_address(iport_address), .iport_wr(iport_wr), .iport_enable(iport_enable),
      .iport_data_i(iport_data_i), .iport_ready(iport_ready), .iport_error(iport_error),
      .dport_address(dport_address), .dport_data_o(dport_data_o), .dport_wr(dport_wr),
      .dport_enable(dport_enable), .dport_data_i(dport_data_i), .dport_ready(dport_ready),
      .dport_error(dport_error),
      .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_wr(mem_wr),
      .mem_enable(mem_enable), .mem_data_i(mem_data_i), .mem_ready(mem_ready),
      .mem_error(mem_error), .grant_d(grant_d), .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: last winner and the data each port last received.
   bit          m_last_d;
   logic [31:0] m_idata, m_ddata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Serve one bus transaction for the expected winner.
   // kind: 0 ready, 1 error, 2 ready+error, 3 no response (timeout).
   // delay: number of idle BUSY cycles before the response.
   task automatic serve(input bit is_d, input int delay, input int kind,
                        input logic [31:0] rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_wr, input logic [31:0] exp_wdata);
      bit seen;
      int n;
      bit exp_rdy, exp_err;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         @(negedge clk);
         seen = mem_enable;
      end
      chk("grant_seen", 32'(seen), 32'd1);
      if (!seen) return;
      chk("grant_d", 32'(grant_d), 32'(is_d));
      chk("mem_address", mem_address, exp_addr);
      chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
      chk("mem_data_o", mem_data_o, exp_wdata);
      if (kind == 3) begin
         n = 1;
         while (n <= int'(3 * T)) begin
            @(negedge clk);
            if (!mem_enable) break;
            n++;
         end
         chk("timeout_cycles", 32'(n), 32'(T));
      end else begin
         for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("busy_hold", 32'(mem_enable), 32'd1);
         end
         mem_ready  = (kind != 1);
         mem_error  = (kind != 0);
         mem_data_i = rdata;
         @(negedge clk);
         mem_ready  = 1'b0;
         mem_error  = 1'b0;
         mem_data_i = $urandom;
      end
      exp_rdy = (kind == 0) || (kind == 2);
      exp_err = (kind != 0);
      if (exp_rdy) begin
         if (is_d) m_ddata = rdata;
         else      m_idata = rdata;
      end
      chk("done_mem_enable", 32'(mem_enable), 32'd0);
      chk("done_busy", 32'(arb_busy), 32'd1);
      if (is_d) begin
         chk("d_ready", 32'(dport_ready), 32'(exp_rdy));
         chk("d_error", 32'(dport_error), 32'(exp_err));
         chk("d_data", dport_data_i, m_ddata);
         chk("i_ready_idle", 32'(iport_ready), 32'd0);
         chk("i_data_hold", iport_data_i, m_idata);
      end else begin
         chk("i_ready", 32'(iport_ready), 32'(exp_rdy));
         chk("i_error", 32'(iport_error), 32'(exp_err));
         chk("i_data", iport_data_i, m_idata);
         chk("d_ready_idle", 32'(dport_ready), 32'd0);
         chk("d_data_hold", dport_data_i, m_ddata);
      end
      m_last_d = is_d;
      if (is_d) dport_enable = 1'b0;
      else      iport_enable = 1'b0;
      @(negedge clk);
      chk("ready_clear", 32'({iport_ready, iport_error, dport_ready, dport_error}), 32'd0);
   endtask

   task automatic raise_i(input logic [31:0] a);
      iport_address = a;
      iport_wr      = 4'b0000;
      iport_enable  = 1'b1;
   endtask

   task automatic raise_d(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
      dport_address = a;
      dport_wr      = w;
      dport_data_o  = wd;
      dport_enable  = 1'b1;
   endtask

   initial begin
      bit pi, pd, win;
      int r, kind;
      logic [31:0] rd;
      rst = 1'b1;
      iport_address = '0; iport_wr = '0; iport_enable = 1'b0;
      dport_address = '0; dport_data_o = '0; dport_wr = '0; dport_enable = 1'b0;
      mem_data_i = '0; mem_ready = 1'b0; mem_error = 1'b0;
      m_last_d = 1'b0; m_idata = '0; m_ddata = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_enable", 32'(mem_enable), 32'd0);
      chk("rst_flags", 32'({grant_d, arb_busy, iport_ready, iport_error, dport_ready, dport_error}), 32'd0);
      chk("rst_data", iport_data_i | dport_data_i | mem_address | mem_data_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Lone instruction read, response three cycles after mem_enable
      raise_i(32'h0000_0100);
      serve(1'b0, 3, 0, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'd0);

      // Simultaneous requests: data first, then instruction
      raise_i(32'h0000_0100);
      raise_d(32'h8000_0040, 4'b1111, 32'h1234_5678);
      serve(1'b1, 1, 0, 32'h0, 32'h8000_0040, 4'b1111, 32'h1234_5678);
      serve(1'b0, 0, 0, 32'hCAFE_0001, 32'h0000_0100, 4'b0000, 32'd0);

      // Continuous contention alternates D, I, D, I
      for (int k = 0; k < 4; k++) begin
         if (!iport_enable) raise_i(32'h0000_1000 + 32'(k));
         if (!dport_enable) raise_d(32'h0000_2000 + 32'(k), 4'b0000, 32'd0);
         serve((k % 2) == 0, 1, 0, 32'hA000_0000 + 32'(k),
               (k % 2) == 0 ? dport_address : iport_address,
               (k % 2) == 0 ? dport_wr : 4'b0000, 32'd0);
      end

      // Timeout on a data read, then ready on the last cycle before timeout
      raise_d(32'h0000_3000, 4'b0000, 32'h5555_5555);
      serve(1'b1, 0, 3, 32'h0, 32'h0000_3000, 4'b0000, 32'h5555_5555);
      raise_d(32'h0000_3004, 4'b0000, 32'h0);
      serve(1'b1, int'(T) - 1, 0, 32'h7777_0000, 32'h0000_3004, 4'b0000, 32'h0);
      // Error alone and error together with ready
      raise_d(32'h0000_3008, 4'b0011, 32'h0000_ABCD);
      serve(1'b1, 0, 1, 32'h0, 32'h0000_3008, 4'b0011, 32'h0000_ABCD);
      raise_i(32'h0000_300C);
      serve(1'b0, 1, 2, 32'h1357_9BDF, 32'h0000_300C, 4'b0000, 32'd0);

      // Abort: instruction flushed one cycle into BUSY, data waits pending
      raise_i(32'h0000_0200);
      @(negedge clk);
      @(negedge clk);
      chk("abort_grant", 32'({mem_enable, grant_d}), 32'b10);
      iport_enable = 1'b0;
      raise_d(32'h0000_0300, 4'b0000, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_hold", 32'({mem_enable, iport_ready, iport_error}), 32'b100);
      end
      mem_ready = 1'b1; mem_data_i = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_ready = 1'b0; mem_data_i = '0;
      chk("abort_idle", 32'({mem_enable, arb_busy, iport_ready, iport_error}), 32'd0);
      chk("abort_data", iport_data_i, m_idata);
      m_last_d = 1'b0;
      serve(1'b1, 0, 0, 32'h2468_ACE0, 32'h0000_0300, 4'b0000, 32'd0);

      // Randomized traffic against the reference priority rule
      pi = 1'b0; pd = 1'b0;
      for (int it = 0; it < 40; it++) begin
         if (!pi && ($urandom_range(0, 1) == 1)) begin
            raise_i($urandom & 32'hFFFF_FFFC);
            pi = 1'b1;
         end
         if (!pd && (($urandom_range(0, 1) == 1) || !pi)) begin
            raise_d($urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), $urandom);
            pd = 1'b1;
         end
         win = pd && (!pi || !m_last_d);
         r = int'($urandom_range(0, 9));
         kind = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
         rd = $urandom;
         if (win) begin
            serve(1'b1, int'($urandom_range(0, 5)), kind, rd,
                  dport_address, dport_wr, dport_data_o);
            pd = 1'b0;
         end else begin
            serve(1'b0, int'($urandom_range(0, 5)), kind, rd,
                  iport_address, 4'b0000, 32'd0);
            pi = 1'b0;
         end
      end
      if (pi) begin
         serve(1'b0, 0, 0, 32'h0F0F_0F0F, iport_address, 4'b0000, 32'd0);
      end

      // Asynchronous reset in the middle of a data transaction
      raise_d(32'h0000_0400, 4'b1111, 32'hFFFF_0000);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", 32'({mem_enable, grant_d, arb_busy}), 32'b111);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", 32'({mem_enable, grant_d, arb_busy}), 32'd0);
      chk("async_rst_bus", mem_address | mem_data_o, 32'd0);
      dport_enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_last_d = 1'b0; m_idata = '0; m_ddata = '0;
      chk("rst_data_clear", dport_data_i, 32'd0);
      raise_i(32'h0000_0500);
      serve(1'b0, 2, 0, 32'h600D_F00D, 32'h0000_0500, 4'b0000, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
